// File: rtl/ss_ctrl_if.sv
// ss_ctrl_if: stack bus between the data-stack controller (master) and the
// EBR-backed stack memory (slave).
//   op : 2'd0 idle, 2'd1 PUSH, 2'd2 POP (driven by master)
//   vi : value to push (driven by master)
//   s  : popped value, valid the cycle after a POP (driven by slave)
interface ss_ctrl_if #(
    parameter int DSZ = 32
);
    logic [1:0]     op;
    logic [DSZ-1:0] vi;
    logic [DSZ-1:0] s;

    modport master (output op, output vi, input s);
    modport slave  (input op, input vi, output s);
endinterface

// File: rtl/ss_ctrl.sv
// ss_ctrl: data-stack controller. Keeps T (tos) and N (nos) in registers,
// executes Forth stack/ALU commands and spills to / refills from the stack
// memory over ss_io.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   ss_io              stack bus, master side (op, vi out; s in)
//   ss_en              memory enable, high exactly when op is PUSH or POP
//   cmd_vld/cmd_rdy    command handshake
//   cmd, imm           opcode and literal
//   err_clr            synchronous clear of both sticky error flags
//   tos, nos, depth    stack registers and item count
//   err_over/err_under sticky error flags
//   state_dbg          1 while the controller is in REFILL
//
// Handshake: a command transfers on a posedge where cmd_vld && cmd_rdy.
// cmd_rdy depends only on state (high in IDLE), never on cmd_vld. A command
// that under/overflows is still consumed; it only sets its error flag.
module ss_ctrl #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int DCW   = $clog2(DEPTH + 3)
) (
    input  logic           clk,
    input  logic           rst,
    ss_ctrl_if.master      ss_io,
    output logic           ss_en,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic [3:0]     cmd,
    input  logic [DSZ-1:0] imm,
    input  logic           err_clr,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [DCW-1:0] depth,
    output logic           err_over,
    output logic           err_under,
    output logic           state_dbg
);
    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    localparam logic [3:0] C_LIT  = 4'd1;
    localparam logic [3:0] C_DUP  = 4'd2;
    localparam logic [3:0] C_DROP = 4'd3;
    localparam logic [3:0] C_SWAP = 4'd4;
    localparam logic [3:0] C_OVER = 4'd5;
    localparam logic [3:0] C_ADD  = 4'd6;
    localparam logic [3:0] C_SUB  = 4'd7;
    localparam logic [3:0] C_AND  = 4'd8;
    localparam logic [3:0] C_OR   = 4'd9;
    localparam logic [3:0] C_XOR  = 4'd10;

    localparam logic [DCW-1:0] D_MAX = DCW'(DEPTH + 2);
    localparam logic [DCW-1:0] D_TWO = DCW'(2);

    typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;
    state_t state;

    logic [DCW-1:0] need;
    logic           grow;
    logic           shrink;
    logic           is_swap;
    logic [DSZ-1:0] grow_val;
    logic [DSZ-1:0] shrink_val;
    logic           accept;
    logic           under;
    logic           over;
    logic           exec;
    logic           spill;
    logic           pop;

    // Command decode: minimum depth and direction of depth change.
    always_comb begin
        need       = '0;
        grow       = 1'b0;
        shrink     = 1'b0;
        is_swap    = 1'b0;
        grow_val   = tos;
        shrink_val = nos;
        case (cmd)
            C_LIT:  begin grow = 1'b1; grow_val = imm; end
            C_DUP:  begin need = DCW'(1); grow = 1'b1; grow_val = tos; end
            C_DROP: begin need = DCW'(1); shrink = 1'b1; shrink_val = nos; end
            C_SWAP: begin need = DCW'(2); is_swap = 1'b1; end
            C_OVER: begin need = DCW'(2); grow = 1'b1; grow_val = nos; end
            C_ADD:  begin need = DCW'(2); shrink = 1'b1; shrink_val = nos + tos; end
            C_SUB:  begin need = DCW'(2); shrink = 1'b1; shrink_val = nos - tos; end
            C_AND:  begin need = DCW'(2); shrink = 1'b1; shrink_val = nos & tos; end
            C_OR:   begin need = DCW'(2); shrink = 1'b1; shrink_val = nos | tos; end
            C_XOR:  begin need = DCW'(2); shrink = 1'b1; shrink_val = nos ^ tos; end
            default: ;
        endcase
    end

    assign cmd_rdy   = (state == S_IDLE);
    assign state_dbg = (state == S_REFILL);
    assign accept    = cmd_vld && cmd_rdy;
    assign under     = (depth < need);
    assign over      = grow && (depth == D_MAX);
    assign exec      = accept && !under && !over;

    // Spill old N when T and N are both occupied; refill N when memory
    // holds something beneath the consumed entry.
    assign spill = exec && grow && (depth >= D_TWO);
    assign pop   = exec && shrink && (depth > D_TWO);

    always_comb begin
        ss_io.op = OP_IDLE;
        ss_io.vi = '0;
        if (spill) begin
            ss_io.op = OP_PUSH;
            ss_io.vi = nos;
        end else if (pop) begin
            ss_io.op = OP_POP;
        end
    end

    assign ss_en = spill || pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tos       <= '0;
            nos       <= '0;
            depth     <= '0;
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exec) begin
                        if (grow) begin
                            tos   <= grow_val;
                            nos   <= tos;
                            depth <= depth + DCW'(1);
                        end else if (shrink) begin
                            tos   <= shrink_val;
                            depth <= depth - DCW'(1);
                            if (depth > D_TWO) begin
                                state <= S_REFILL;
                            end else begin
                                nos <= '0;
                            end
                        end else if (is_swap) begin
                            tos <= nos;
                            nos <= tos;
                        end
                    end
                end
                S_REFILL: begin
                    // Memory presents the popped value this cycle.
                    nos   <= ss_io.s;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Clear wins over an error raised in the same cycle.
            if (err_clr) begin
                err_over  <= 1'b0;
                err_under <= 1'b0;
            end else begin
                if (accept && under) err_under <= 1'b1;
                if (accept && !under && over) err_over <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ss_ctrl.sv
module tb_ss_ctrl;
  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int DCW   = $clog2(DEPTH + 3);

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           ss_en;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [3:0]     cmd;
  logic [DSZ-1:0] imm;
  logic           err_clr;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [DCW-1:0] depth;
  logic           err_over;
  logic           err_under;
  logic           state_dbg;

  ss_ctrl_if #(.DSZ(DSZ)) ss_io ();

  ss_ctrl #(.DEPTH(DEPTH), .DSZ(DSZ), .DCW(DCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_io     (ss_io),
    .ss_en     (ss_en),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd       (cmd),
    .imm       (imm),
    .err_clr   (err_clr),
    .tos       (tos),
    .nos       (nos),
    .depth     (depth),
    .err_over  (err_over),
    .err_under (err_under),
    .state_dbg (state_dbg)
  );

  // ---------------- stack memory responder ----------------
  logic [DSZ-1:0] mem [DEPTH];
  int mptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mptr <= 0;
      ss_io.s <= '0;
    end else if (ss_en) begin
      if (ss_io.op == OP_PUSH && mptr < DEPTH) begin
        mem[mptr] <= ss_io.vi;
        mptr <= mptr + 1;
      end else if (ss_io.op == OP_POP && mptr > 0) begin
        ss_io.s <= mem[mptr-1];
        mptr <= mptr - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Whole stack as a queue, element 0 is the top.
  logic [DSZ-1:0] st[$];
  logic [DSZ-1:0] exp_q[$];   // expected spill values
  bit m_refill, m_eo, m_eu;

  int n_cmp = 0;
  int n_fail = 0;
  int bus_ops = 0;
  logic [1:0]     last_op;
  logic [DSZ-1:0] last_vi;

  function automatic int need_of(input logic [3:0] c);
    case (c)
      4'd2, 4'd3: return 1;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int delta_of(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd5: return 1;
      4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: return -1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    st.delete();
    exp_q.delete();
    m_refill = 0;
    m_eo = 0;
    m_eu = 0;
  endtask

  task automatic model_update(input bit vld, input logic [3:0] c,
                              input logic [DSZ-1:0] im, input bit clr);
    int sz;
    logic [DSZ-1:0] t, n, r;
    sz = st.size();
    if (m_refill) begin
      m_refill = 0;
    end else if (vld) begin
      if (sz < need_of(c)) m_eu = 1;
      else if (delta_of(c) == 1 && sz == DEPTH + 2) m_eo = 1;
      else begin
        case (c)
          4'd1: st.push_front(im);
          4'd2: begin t = st[0]; st.push_front(t); end
          4'd5: begin n = st[1]; st.push_front(n); end
          4'd4: begin t = st[0]; st[0] = st[1]; st[1] = t; end
          4'd3: t = st.pop_front();
          4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
            t = st.pop_front();
            n = st.pop_front();
            case (c)
              4'd6: r = n + t;
              4'd7: r = n - t;
              4'd8: r = n & t;
              4'd9: r = n | t;
              default: r = n ^ t;
            endcase
            st.push_front(r);
          end
          default: ;
        endcase
        if (delta_of(c) == -1 && sz > 2) m_refill = 1;
      end
    end
    if (clr) begin
      m_eo = 0;
      m_eu = 0;
    end
  endtask

  task automatic check_regs();
    chk("tos", tos, (st.size() > 0) ? st[0] : '0);
    if (!m_refill) chk("nos", nos, (st.size() > 1) ? st[1] : '0);
    chk("depth", depth, 64'(st.size()));
    chk("err_over", err_over, m_eo);
    chk("err_under", err_under, m_eu);
    chk("refill_state", state_dbg, m_refill);
  endtask

  // ---------------- driver: one cycle per call ----------------
  task automatic step(input bit vld, input logic [3:0] c,
                      input logic [DSZ-1:0] im, input bit clr);
    int sz;
    bit ok;
    logic [1:0] e_op;
    cmd_vld = vld;
    cmd = c;
    imm = im;
    err_clr = clr;
    #1;
    sz = st.size();
    ok = vld && !m_refill && sz >= need_of(c) && !(delta_of(c) == 1 && sz == DEPTH + 2);
    e_op = OP_IDLE;
    if (ok && delta_of(c) == 1 && sz >= 2) begin
      e_op = OP_PUSH;
      exp_q.push_back(st[1]);
    end else if (ok && delta_of(c) == -1 && sz > 2) begin
      e_op = OP_POP;
    end
    chk("cmd_rdy", cmd_rdy, !m_refill);
    chk("op", ss_io.op, e_op);
    chk("ss_en", ss_en, e_op != OP_IDLE);
    if (ss_io.op == OP_PUSH) begin
      if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
      else chk("spill_vi", ss_io.vi, exp_q.pop_front());
    end
    last_op = ss_io.op;
    last_vi = ss_io.vi;
    if (ss_io.op != OP_IDLE) bus_ops++;
    @(posedge clk);
    model_update(vld, c, im, clr);
    #1;
    check_regs();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    cmd_vld = 1'b0;
    cmd = '0;
    imm = '0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [DSZ-1:0] fill_v [DEPTH+2];
  logic [3:0] pick [12];

  initial begin
    pick[0] = 4'd1;  pick[1] = 4'd2;  pick[2] = 4'd3;  pick[3] = 4'd4;
    pick[4] = 4'd5;  pick[5] = 4'd10; pick[6] = 4'd5;  pick[7] = 4'd4;
    pick[8] = 4'd6;  pick[9] = 4'd7;  pick[10] = 4'd0; pick[11] = 4'd12;

    apply_reset();
    chk("rst_tos", tos, 0);
    chk("rst_depth", depth, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);

    // LIT 5, LIT 7, ADD
    bus_ops = 0;
    step(1, 4'd1, 32'd5, 0);
    step(1, 4'd1, 32'd7, 0);
    step(1, 4'd6, 32'd0, 0);
    chk("add_tos", tos, 12);
    chk("add_depth", depth, 1);
    chk("add_no_bus", bus_ops, 0);
    chk("add_err", {err_over, err_under}, 0);

    // spill and refill
    apply_reset();
    step(1, 4'd1, 32'd1, 0);
    step(1, 4'd1, 32'd2, 0);
    step(1, 4'd1, 32'd3, 0);
    chk("spill_op", last_op, OP_PUSH);
    chk("spill_val", last_vi, 1);
    step(1, 4'd3, 32'd0, 0);
    chk("drop_op", last_op, OP_POP);
    chk("refill_rdy_low", cmd_rdy, 0);
    step(0, 4'd0, 32'd0, 0);
    chk("refill_rdy_back", cmd_rdy, 1);
    chk("refill_tos", tos, 2);
    chk("refill_nos", nos, 1);
    chk("refill_depth", depth, 2);

    // fill to capacity then overflow
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      fill_v[i] = $urandom;
      step(1, 4'd1, fill_v[i], 0);
    end
    step(1, 4'd2, 32'd0, 0);
    chk("ovf_flag", err_over, 1);
    chk("ovf_depth", depth, DEPTH + 2);
    chk("ovf_tos", tos, fill_v[DEPTH+1]);
    chk("ovf_nos", nos, fill_v[DEPTH]);
    step(0, 4'd0, 32'd0, 1);
    chk("ovf_clr", err_over, 0);
    // drain a few to exercise refills from a deep memory
    for (int i = 0; i < 6; i++) step(1, 4'd3, 32'd0, 0);

    // underflow
    apply_reset();
    step(1, 4'd3, 32'd0, 0);
    chk("unf_flag", err_under, 1);
    chk("unf_no_bus", last_op, OP_IDLE);
    step(1, 4'd1, 32'd9, 0);
    step(1, 4'd4, 32'd0, 0);
    chk("unf_swap_flag", err_under, 1);
    chk("unf_swap_tos", tos, 9);

    // subtraction
    apply_reset();
    step(1, 4'd1, 32'd10, 0);
    step(1, 4'd1, 32'd3, 0);
    step(1, 4'd7, 32'd0, 0);
    chk("sub_tos", tos, 7);
    step(1, 4'd1, 32'd0, 0);
    step(1, 4'd1, 32'd1, 0);
    step(1, 4'd7, 32'd0, 0);
    chk("sub_wrap", tos, 32'hFFFF_FFFF);

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] c;
      c = pick[$urandom_range(0, 11)];
      if (st.size() < 3 && $urandom_range(0, 1) == 1) c = 4'd1;
      if (st.size() > 20 && $urandom_range(0, 1) == 1) c = 4'd8;
      step($urandom_range(0, 3) != 0, c, $urandom, $urandom_range(0, 15) == 0);
    end

    // reset during REFILL
    apply_reset();
    step(1, 4'd1, 32'd4, 0);
    step(1, 4'd1, 32'd5, 0);
    step(1, 4'd1, 32'd6, 0);
    step(1, 4'd9, 32'd0, 0);
    chk("pre_rst_refill", state_dbg, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_tos", tos, 0);
    chk("arst_nos", nos, 0);
    chk("arst_depth", depth, 0);
    chk("arst_err", {err_over, err_under}, 0);
    chk("arst_state", state_dbg, 0);
    chk("arst_bus", {ss_en, ss_io.op}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("arst_rdy", cmd_rdy, 1);
    step(1, 4'd1, 32'd11, 0);
    chk("arst_after_tos", tos, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
